// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated frequency counter; define FREQ_METER_CONTINUOUS_EN for back-to-back windows
module freq_meter #(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sig_in,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             valid,
    output logic             overflow
);

    localparam int GW = $clog2(GATE_CYCLES + 1);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             clear;
    logic             s1;
    logic             s2;
    logic             sd;
    logic             edge_pulse;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] edge_nxt;
    logic             ovf;
    logic             ovf_nxt;
    logic             gate_end;

    // Two-flop synchroniser for the asynchronous input plus a delay flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            sd <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            sd <= s2;
        end
    end

    assign edge_pulse = s2 & ~sd;
    assign gate_end   = (state == MEASURE) && (gate_cnt == GATE_LAST);

    // Saturating increment of the edge counter; an increment attempted at full scale flags overflow
    always_comb begin
        edge_nxt = edge_cnt;
        ovf_nxt  = ovf;
        if (edge_pulse) begin
            if (edge_cnt == CNT_MAX) begin
                ovf_nxt = 1'b1;
            end else begin
                edge_nxt = edge_cnt + CNT_W'(1);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic, counter clear on window entry, status outputs
    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        busy      = 1'b0;
        valid     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = MEASURE;
                    clear     = 1'b1;
                end
            end
            MEASURE: begin
                busy = 1'b1;
                if (gate_cnt == GATE_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                valid = 1'b1;
`ifdef FREQ_METER_CONTINUOUS_EN
                state_nxt = MEASURE;
                clear     = 1'b1;
`else
                state_nxt = IDLE;
`endif
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Window counters; the result registers capture the final count (including a last-cycle edge) as DONE is entered
    always_ff @(posedge clk) begin
        if (rst) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf      <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf      <= 1'b0;
        end else if (state == MEASURE) begin
            gate_cnt <= gate_cnt + GW'(1);
            edge_cnt <= edge_nxt;
            ovf      <= ovf_nxt;
            if (gate_end) begin
                count    <= edge_nxt;
                overflow <= ovf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - self-checking bench for freq_meter (16-bit and 4-bit counter instances)
`timescale 1ns/1ps
module tb_freq_meter;

    localparam int G = 1000;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        start  = 1'b0;
    logic        sig_in = 1'b0;
    logic        busy, valid, overflow;
    logic [15:0] count;
    logic        busy4, valid4, overflow4;
    logic [3:0]  count4;

    int  cyc   = 0;
    int  mode  = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    bit  en    = 1'b0;
    bit  rst_q, start_q;
    real rises[$];

    // Model state
    bit  run = 1'b0;
    int  run_t = 0;
    real mb = 0.0;
    int  lo = 0, hi = 0, lo4 = 0, hi4 = 0, ov4 = 0;

    freq_meter #(.GATE_CYCLES(G), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .sig_in(sig_in),
        .busy(busy), .count(count), .valid(valid), .overflow(overflow)
    );

    freq_meter #(.GATE_CYCLES(G), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .sig_in(sig_in),
        .busy(busy4), .count(count4), .valid(valid4), .overflow(overflow4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rst_q   <= rst;
        start_q <= start;
    end

    // mode: 0 hold low, 1 hold high, 2 = 8 MHz, 3 = 16 MHz
    initial begin
        sig_in = 1'b0;
        #2.3;
        forever begin
            case (mode)
                2:       begin #62.5;  sig_in = ~sig_in; end
                3:       begin #31.25; sig_in = ~sig_in; end
                1:       begin sig_in = 1'b1; #1; end
                default: begin sig_in = 1'b0; #1; end
            endcase
        end
    end

    always @(posedge sig_in) rises.push_back($realtime);

    function automatic int rises_in(real a, real b);
        int c = 0;
        foreach (rises[i]) if (rises[i] >= a && rises[i] < b) c++;
        return c;
    endfunction

    function automatic bit model_idle(int x);
`ifdef FREQ_METER_CONTINUOUS_EN
        return !run;
`else
        return !run || (x - run_t >= G + 2);
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int l, input int h);
        n_cmp++;
        if (act < l || act > h) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, l, h, cyc);
        end
    endtask

    // Model: window timing from start cycle, count from the recorded sig_in rise times (+-1 for sync jitter)
    always @(negedge clk) begin
        int  d, n;
        real wb;
        bit  eb, ev;
`ifdef FREQ_METER_CONTINUOUS_EN
        int  p, k;
`endif
        if (en) begin
            if (rst_q) begin
                run = 1'b0;
                lo = 0; hi = 0; lo4 = 0; hi4 = 0; ov4 = 0;
            end else if (start_q && model_idle(cyc - 1)) begin
                run   = 1'b1;
                run_t = cyc - 1;
                mb    = $realtime - 5.0;
            end
            eb = 1'b0;
            ev = 1'b0;
            wb = mb;
            if (run) begin
                d = cyc - run_t;
`ifdef FREQ_METER_CONTINUOUS_EN
                if (d >= 1) begin
                    p  = (d - 1) % (G + 1);
                    k  = (d - 1) / (G + 1);
                    eb = (p < G);
                    ev = (p == G);
                    wb = mb + real'(k) * real'(G + 1) * 10.0;
                end
`else
                eb = (d >= 1 && d <= G);
                ev = (d == G + 1);
`endif
                if (ev) begin
                    n   = rises_in(wb - 25.0, wb + real'(G) * 10.0 - 25.0);
                    lo  = (n > 0) ? n - 1 : 0;
                    hi  = n + 1;
                    lo4 = (lo < 15) ? lo : 15;
                    hi4 = (hi < 15) ? hi : 15;
                    ov4 = (lo >= 16) ? 1 : ((hi <= 15) ? 0 : -1);
                end
            end
            check("busy", int'(busy), int'(eb));
            check("valid", int'(valid), int'(ev));
            check("busy4", int'(busy4), int'(eb));
            check("valid4", int'(valid4), int'(ev));
            check_rng("count", int'(count), lo, hi);
            check_rng("count4", int'(count4), lo4, hi4);
            check("overflow", int'(overflow), 0);
            if (ov4 >= 0) check("overflow4", int'(overflow4), ov4);
        end
    end

    task automatic pulse_start(output int t);
        @(posedge clk); #1 start = 1'b1;
        t = cyc;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int vc);
        bit ok = 1'b0;
        vc = -1;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (valid) begin
                ok = 1'b1;
                vc = cyc;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL valid_timeout: got no valid, expected one within %0d cycles", limit);
        end
    endtask

    task automatic count_valids(input int ncyc, output int nv);
        nv = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (valid) nv++;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        int t, t2, vc, nv, prev;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        en = 1'b1;
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_count", int'(count), 0);
        check("rst_overflow", int'(overflow), 0);

`ifdef FREQ_METER_CONTINUOUS_EN
        mode = 2;
        repeat (20) @(posedge clk);
        pulse_start(t);
        prev = t;
        for (int w = 0; w < 5; w++) begin
            wait_valid(1100, vc);
            check("cont_period", vc - prev, 1001);
            check_rng("cont_cnt_8m", int'(count), 79, 81);
            prev = vc;
        end
`else
        // 8 MHz: 80 edges per 10 us window; the 4-bit instance saturates
        mode = 2;
        repeat (20) @(posedge clk);
        pulse_start(t);
        wait_valid(1100, vc);
        check("lat_8m", vc - t, 1001);
        check_rng("cnt_8m", int'(count), 79, 81);
        check("ovf_8m", int'(overflow), 0);
        check("cnt4_8m", int'(count4), 15);
        check("ovf4_8m", int'(overflow4), 1);

        // 16 MHz, two runs
        mode = 3;
        repeat (10) @(posedge clk);
        for (int r = 0; r < 2; r++) begin
            pulse_start(t);
            wait_valid(1100, vc);
            check("lat_16m", vc - t, 1001);
            check_rng("cnt_16m", int'(count), 159, 161);
            check("cnt4_16m", int'(count4), 15);
            check("ovf4_16m", int'(overflow4), 1);
        end

        // Input held low: zero edges, overflow clears
        mode = 0;
        repeat (10) @(posedge clk);
        pulse_start(t);
        wait_valid(1100, vc);
        check("cnt_zero", int'(count), 0);
        check("cnt4_zero", int'(count4), 0);
        check("ovf4_zero", int'(overflow4), 0);

        // start re-pulsed mid-window is ignored
        mode = 2;
        repeat (10) @(posedge clk);
        pulse_start(t);
        repeat (300) @(posedge clk);
        pulse_start(t2);
        wait_valid(1100, vc);
        check("lat_restart", vc - t, 1001);
        count_valids(1100, nv);
        check("extra_valid", nv, 0);

        // Reset around gate cycle 500 discards the window
        pulse_start(t);
        repeat (498) @(posedge clk);
        do_reset();
        @(negedge clk);
        check("midrst_busy", int'(busy), 0);
        check("midrst_count", int'(count), 0);
        check("midrst_count4", int'(count4), 0);
        check("midrst_ovf4", int'(overflow4), 0);
        count_valids(1200, nv);
        check("midrst_valid", nv, 0);

        // Idle toggling and a held-high level are not counted
        mode = 3;
        repeat (200) @(posedge clk);
        mode = 1;
        repeat (20) @(posedge clk);
        pulse_start(t);
        wait_valid(1100, vc);
        check("cnt_held_hi", int'(count), 0);
        check("cnt4_held_hi", int'(count4), 0);
`endif
        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
# freq_meter

Gated frequency counter that measures a slow, asynchronous square wave, such as the 16 MHz / 8 MHz test clocks, against the system clock. It sits directly downstream of the clock-generation stage. It synchronises the incoming signal, counts its rising edges over a fixed window of `GATE_CYCLES` system-clock cycles, and reports the count with a one-cycle valid strobe. Self-check benches and bring-up logic use it to confirm that generated clock frequencies are correct.

## Interface
- `GATE_CYCLES`, default 1000: measurement window length in `clk` cycles; must be ≥ 2.
- `CNT_W`, default 16: width of the edge counter and of `count`.
- `clk` input 1: system/reference clock; all logic is on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle request to begin a measurement; sampled only in IDLE.
- `sig_in` input 1: asynchronous signal under measurement.
- `busy` output 1: high while a measurement is in progress (MEASURE state).
- `count` output `CNT_W`: rising-edge count of the last completed window; held until the next DONE.
- `valid` output 1: single-cycle strobe when `count` updates.
- `overflow` output 1: high if the last window's count saturated; updates together with `count`.

## Operation
- Synchroniser: `sig_in` passes through a 2-FF chain (`s1`, `s2`), followed by a delay register `sd`. The edge pulse is `s2 & ~sd`.
- FSM with three states:
  - IDLE → MEASURE when `start` = 1. On entry, the edge counter and the gate counter are both cleared to 0.
  - MEASURE: the gate counter increments every cycle. The edge counter increments in every cycle with an edge pulse. The FSM moves to DONE after exactly `GATE_CYCLES` cycles in MEASURE.
  - DONE lasts one cycle: `count` and `overflow` are loaded, `valid` = 1, then the FSM returns to IDLE (see Configuration).
- Edge pulses outside MEASURE are ignored. An edge in the first MEASURE cycle counts; an edge in the DONE cycle does not.
- The edge counter saturates at 2^`CNT_W`−1 and never wraps. Any increment attempted at saturation sets an internal overflow flag, which is cleared on MEASURE entry.
- `start` while `busy` or in DONE is ignored. There is no queuing.
- Input constraint: `sig_in` high and low phases must each be ≥ 2 `clk` periods. Faster inputs give unspecified counts.

## Timing
- Reset values: `busy` = 0, `count` = 0, `valid` = 0, `overflow` = 0. FSM is in IDLE; synchroniser flops, `sd` and both counters are 0.
- `start` high at cycle T: `busy` rises at T+1 and stays high for `GATE_CYCLES` cycles. `valid` pulses at T+1+`GATE_CYCLES`, with `busy` low in that cycle.
- Edge latency: a `sig_in` rise is counted 2–3 `clk` cycles after it occurs, because of synchroniser uncertainty. The reported count is therefore the true edge count in the window ±1.
- `rst` asserted at any time, including mid-MEASURE or DONE: the next cycle shows all reset values. The partial measurement is discarded and no `valid` is issued.
- Minimum start-to-start spacing is `GATE_CYCLES`+2 cycles.

## Configuration
- `FREQ_METER_CONTINUOUS_EN` defined:
  - DONE returns directly to MEASURE and clears both counters, so back-to-back windows run with no gap after the first `start`.
  - `valid` strobes every `GATE_CYCLES`+1 cycles.
  - `start` is ignored once running; only `rst` stops the block.
- Not defined: single-shot behaviour as described above (DONE → IDLE).

## Test plan
- 100 MHz `clk`, `GATE_CYCLES` = 1000, `sig_in` = 8 MHz, pulse `start` → one `valid` 1001 cycles after `start`; `count` ∈ {79, 80, 81}; `overflow` = 0.
- Same setup with `sig_in` = 16 MHz → `count` ∈ {159, 160, 161}; repeated `start` gives consistent results.
- `CNT_W` = 4, `sig_in` = 16 MHz → `count` = 15, `overflow` = 1. The next run with `sig_in` held at 0 → `count` = 0, `overflow` = 0.
- `start` re-pulsed mid-MEASURE → ignored; exactly one `valid`. `rst` asserted at gate cycle 500 → outputs read 0 the next cycle and no `valid` follows.
- `sig_in` toggling while IDLE, then `start` with `sig_in` held at 1 → `count` = 0, confirming idle edges and the held level are not counted.
- With `FREQ_METER_CONTINUOUS_EN` and 8 MHz input → `valid` every 1001 cycles for at least 5 windows, each `count` ∈ {79, 80, 81}.
